// File: rtl/i2c_cmd_sequencer.sv
// Command sequencer in front of the I2C master: accepts read/write requests,
// drives the master's start/ready handshake, supplies write bytes and collects read bytes.
module i2c_cmd_sequencer #(
  parameter logic [6:0]  DEV_ADDR = 7'h40,
  parameter int unsigned MAX_SIZE = 4,
  parameter int unsigned RD_BYTES = 2,
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic [2:0]              req_size,
  input  logic [8*MAX_SIZE-1:0]   wr_data,
  input  logic                    auto_en,
  input  logic [PERIOD_W-1:0]     auto_period,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [8*RD_BYTES-1:0]   rd_buffer,
  output logic                    start,
  input  logic                    ready,
  input  logic                    i2c_busy,
  input  logic                    data_available,
  input  logic                    data_request,
  output logic                    data_valid,
  output logic                    read_nwrite,
  output logic [6:0]              addr,
  output logic [7:0]              data_i,
  input  logic [7:0]              data_o,
  output logic [2:0]              data_size
);

  localparam int unsigned WR_W = 8 * MAX_SIZE;
  localparam int unsigned RB_W = 8 * RD_BYTES;
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;

  state_t               state, state_n;
  logic                 start_n, busy_n, done_n, err_n, rnw_n;
  logic [2:0]           size_n;
  logic [WR_W-1:0]      wr_q, wr_n;
  logic [2:0]           idx_q, idx_n;
  logic [RB_W-1:0]      rd_buffer_n;
  logic [7:0]           data_i_n;
  logic [PERIOD_W-1:0]  cnt_q, cnt_n;
  logic [WD_W-1:0]      wd_q, wd_n;
  logic                 da_q, dr_q;

  logic da_rise, dr_rise, size_ok, auto_armed, auto_hit, any_req, rd_dir, wd_expired;
  logic unused;

  assign data_valid = 1'b1;
  assign addr       = DEV_ADDR;
  assign unused     = i2c_busy;

  // Master strobes are sampled on clk; only their rising edges matter.
  assign da_rise    = data_available & ~da_q;
  assign dr_rise    = data_request & ~dr_q;

  assign size_ok    = (req_size != 3'd0) && (req_size <= 3'(MAX_SIZE));
  assign auto_armed = auto_en && (auto_period != '0);
  assign auto_hit   = auto_armed && (cnt_q == auto_period - PERIOD_W'(1));
  assign any_req    = req_read | req_write | auto_hit;
  // Explicit requests beat the auto read; read beats write.
  assign rd_dir     = (req_read | req_write) ? req_read : 1'b1;
  assign wd_expired = ((state == START) || (state == XFER)) && (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_n     = state;
    start_n     = start;
    busy_n      = busy;
    done_n      = 1'b0;
    err_n       = err;
    rnw_n       = read_nwrite;
    size_n      = data_size;
    wr_n        = wr_q;
    idx_n       = idx_q;
    rd_buffer_n = rd_buffer;
    cnt_n       = '0;
    wd_n        = '0;
    data_i_n    = '0;

    case (state)
      IDLE: begin
        if (auto_armed && !auto_hit) cnt_n = cnt_q + PERIOD_W'(1);
        if (any_req) begin
          if (size_ok) begin
            state_n = START;
            start_n = 1'b1;
            busy_n  = 1'b1;
            err_n   = 1'b0;
            rnw_n   = rd_dir;
            size_n  = req_size;
            wr_n    = wr_data;
            idx_n   = 3'd0;
            cnt_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      START: begin
        wd_n = wd_q + WD_W'(1);
        if (!ready) begin
          start_n = 1'b0;
          state_n = XFER;
        end
      end
      XFER: begin
        wd_n = wd_q + WD_W'(1);
        if (read_nwrite && da_rise) rd_buffer_n = RB_W'({rd_buffer, data_o});
        if (!read_nwrite && dr_rise && (idx_q < data_size - 3'd1)) idx_n = idx_q + 3'd1;
        if (ready) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        size_n  = 3'd0;
      end
      default: state_n = IDLE;
    endcase

    // Watchdog abort: back to IDLE with err, no done pulse, read bytes kept.
    if (wd_expired) begin
      state_n = IDLE;
      start_n = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b1;
      size_n  = 3'd0;
      wd_n    = '0;
    end

    for (int i = 0; i < int'(MAX_SIZE); i++) begin
      if (idx_n == 3'(i)) data_i_n = wr_n[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      read_nwrite <= 1'b0;
      data_size   <= 3'd0;
      wr_q        <= '0;
      idx_q       <= 3'd0;
      rd_buffer   <= '0;
      data_i      <= 8'd0;
      cnt_q       <= '0;
      wd_q        <= '0;
      da_q        <= 1'b0;
      dr_q        <= 1'b0;
    end else begin
      state       <= state_n;
      start       <= start_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
      read_nwrite <= rnw_n;
      data_size   <= size_n;
      wr_q        <= wr_n;
      idx_q       <= idx_n;
      rd_buffer   <= rd_buffer_n;
      data_i      <= data_i_n;
      cnt_q       <= cnt_n;
      wd_q        <= wd_n;
      da_q        <= data_available;
      dr_q        <= data_request;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer; the master handshake is driven by hand.
module tb_i2c_cmd_sequencer;

  logic        clk, rst_n;
  logic        req_read, req_write;
  logic [2:0]  req_size;
  logic [31:0] wr_data;
  logic        auto_en;
  logic [23:0] auto_period;
  logic        busy, done, err;
  logic [15:0] rd_buffer;
  logic        start, ready, i2c_busy, data_available, data_request;
  logic        data_valid, read_nwrite;
  logic [6:0]  addr;
  logic [7:0]  data_i, data_o;
  logic [2:0]  data_size;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int d0, n;
  logic seen;

  i2c_cmd_sequencer #(
    .DEV_ADDR(7'h40), .MAX_SIZE(4), .RD_BYTES(2), .PERIOD_W(24), .TIMEOUT(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .req_size(req_size), .wr_data(wr_data), .auto_en(auto_en), .auto_period(auto_period),
    .busy(busy), .done(done), .err(err), .rd_buffer(rd_buffer), .start(start),
    .ready(ready), .i2c_busy(i2c_busy), .data_available(data_available),
    .data_request(data_request), .data_valid(data_valid), .read_nwrite(read_nwrite),
    .addr(addr), .data_i(data_i), .data_o(data_o), .data_size(data_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_dr();
    data_request = 1'b1;
    @(negedge clk);
    data_request = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_da(input logic [7:0] b);
    data_o = b;
    data_available = 1'b1;
    @(negedge clk);
    data_available = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start(input int limit, output int cnt);
    cnt = 0;
    while (!start && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; req_read = 0; req_write = 0; req_size = 0; wr_data = 0;
    auto_en = 0; auto_period = 0; ready = 1; i2c_busy = 0;
    data_available = 0; data_request = 0; data_o = 0;
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdbuf", rd_buffer, 0);
    chk("rst_rnw", read_nwrite, 0);
    chk("rst_size", data_size, 0);
    chk("rst_data_i", data_i, 0);
    chk("addr", addr, 32'h40);
    chk("data_valid", data_valid, 1);
    rst_n = 1;
    @(negedge clk);

    // Write of 3 bytes
    req_write = 1; req_size = 3; wr_data = 32'h00A0_1202;
    @(negedge clk);
    req_write = 0;
    chk("wr_start", start, 1);
    chk("wr_rnw", read_nwrite, 0);
    chk("wr_size", data_size, 3);
    chk("wr_byte0", data_i, 32'h02);
    @(negedge clk);
    chk("wr_start_held", start, 1);
    ready = 0;
    @(negedge clk);
    chk("wr_start_drop", start, 0);
    chk("wr_busy", busy, 1);
    pulse_dr();
    chk("wr_byte1", data_i, 32'h12);
    pulse_dr();
    chk("wr_byte2", data_i, 32'hA0);
    pulse_dr();
    chk("wr_byte_sat", data_i, 32'hA0);
    d0 = done_cnt;
    ready = 1;
    @(negedge clk);
    chk("wr_done", done, 1);
    chk("wr_err", err, 0);
    @(negedge clk);
    chk("wr_done_end", done, 0);
    chk("wr_idle_busy", busy, 0);
    chk("wr_idle_size", data_size, 0);
    @(negedge clk);
    chk("wr_done_cnt", done_cnt, d0 + 1);

    // Read of 2 bytes
    req_read = 1; req_size = 2;
    @(negedge clk);
    req_read = 0;
    chk("rd_start", start, 1);
    chk("rd_rnw", read_nwrite, 1);
    chk("rd_size", data_size, 2);
    ready = 0;
    @(negedge clk);
    pulse_da(8'h5C);
    pulse_da(8'h3E);
    d0 = done_cnt;
    ready = 1;
    @(negedge clk);
    chk("rd_done", done, 1);
    @(negedge clk);
    chk("rd_buffer", rd_buffer, 32'h5C3E);
    @(negedge clk);
    chk("rd_done_cnt", done_cnt, d0 + 1);

    // Simultaneous read+write, then a write request mid-transfer
    req_read = 1; req_write = 1; req_size = 1;
    @(negedge clk);
    req_read = 0; req_write = 0;
    chk("both_rnw", read_nwrite, 1);
    ready = 0;
    @(negedge clk);
    req_write = 1; req_size = 2;
    @(negedge clk);
    req_write = 0;
    chk("ign_busy", busy, 1);
    chk("ign_size", data_size, 1);
    chk("ign_rnw", read_nwrite, 1);
    chk("ign_start", start, 0);
    pulse_da(8'h77);
    ready = 1;
    @(negedge clk);
    chk("both_done", done, 1);
    @(negedge clk);
    chk("both_rdbuf", rd_buffer, 32'h3E77);

    // Illegal sizes
    req_write = 1; req_size = 0;
    @(negedge clk);
    req_write = 0;
    chk("sz0_err", err, 1);
    chk("sz0_start", start, 0);
    chk("sz0_busy", busy, 0);
    req_write = 1; req_size = 5;
    @(negedge clk);
    req_write = 0;
    chk("sz5_err", err, 1);
    chk("sz5_start", start, 0);
    @(negedge clk);
    chk("sz5_start_later", start, 0);
    req_write = 1; req_size = 1;
    @(negedge clk);
    req_write = 0;
    chk("clr_err", err, 0);
    chk("clr_start", start, 1);
    ready = 0;
    @(negedge clk);
    ready = 1;
    @(negedge clk);
    @(negedge clk);

    // Auto read mode
    d0 = done_cnt;
    req_size = 2; auto_period = 24'd10; auto_en = 1;
    wait_start(40, n);
    chk("auto_first", n, 10);
    ready = 0;
    @(negedge clk);
    ready = 1;
    @(negedge clk);
    chk("auto_done", done, 1);
    wait_start(40, n);
    chk("auto_second", n, 11);
    ready = 0;
    @(negedge clk);
    ready = 1;
    @(negedge clk);
    auto_period = 0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | start;
    end
    chk("auto_off", seen, 0);
    chk("auto_done_cnt", done_cnt, d0 + 2);
    auto_en = 0;

    // Watchdog: master never raises ready again
    d0 = done_cnt;
    req_read = 1; req_size = 1;
    @(negedge clk);
    req_read = 0;
    chk("wd_start", start, 1);
    ready = 0;
    @(negedge clk);
    data_o = 8'hC4; data_available = 1;
    @(negedge clk);
    data_available = 0;
    repeat (47) @(negedge clk);
    chk("wd_busy_before", busy, 1);
    chk("wd_err_before", err, 0);
    @(negedge clk);
    chk("wd_busy", busy, 0);
    chk("wd_err", err, 1);
    chk("wd_start_low", start, 0);
    chk("wd_size", data_size, 0);
    chk("wd_rdbuf", rd_buffer, 32'h77C4);
    @(negedge clk);
    chk("wd_no_done", done_cnt, d0);
    ready = 1;
    @(negedge clk);

    // Asynchronous reset in the middle of a transfer
    req_read = 1; req_size = 2; wr_data = 32'h0000_BEEF;
    @(negedge clk);
    req_read = 0;
    ready = 0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_data_i", data_i, 32'hEF);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_start", start, 0);
    chk("arst_rnw", read_nwrite, 0);
    chk("arst_size", data_size, 0);
    chk("arst_data_i", data_i, 0);
    chk("arst_rdbuf", rd_buffer, 0);
    chk("arst_err", err, 0);
    ready = 1;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
